// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 64-bit shift-right LFSR
// pattern generator (next = {d[1]^d[0], d[W-1:1]}).
// It hunts for a run of correctly predicted words, then locks and free-runs
// its own predictor while counting mismatched and checked words.
// Optional macro PRBS_CHECKER_BIT_ERR_EN adds a saturating bit-error counter
// (bit_err_count). It accumulates popcount(in_data ^ expected) on every word
// checked while LOCKED.
module prbs_checker #(
  parameter int WIDTH    = 64,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
`ifdef PRBS_CHECKER_BIT_ERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_count
`endif
);

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
  localparam logic [7:0]       LOSS_N  = 8'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] ref_reg;
  logic             ref_vld_reg;
  logic [3:0]       match_cnt_reg;
  logic [7:0]       bad_cnt_reg;

  logic [WIDTH-1:0] exp_word;
  logic             mismatch;
  logic             hunt_match;

  // Saturating increment: all-ones is sticky so software never sees a wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Predicted word is always derived from the stored reference.
  assign exp_word = {ref_reg[1] ^ ref_reg[0], ref_reg[WIDTH-1:1]};
  assign mismatch = (in_data != exp_word);

  // Zero is the LFSR lock-up state, so it can never count as a match.
  assign hunt_match = ref_vld_reg && !mismatch && (in_data != '0);

  assign locked = (state_reg == LOCKED);

`ifdef PRBS_CHECKER_BIT_ERR_EN
  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] diff_bits;
  logic [PW-1:0]    pop;
  logic [CNT_W:0]   bit_sum;
  logic [CNT_W-1:0] bit_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff_bits[gi] = in_data[gi] ^ exp_word[gi];
    end
  endgenerate

  // Popcount of the error bits in the current word.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(diff_bits[i]);
    end
  end

  // Saturating accumulate: clamp to all-ones if the add carries out.
  always_comb begin
    bit_sum  = {1'b0, bit_err_count} + (CNT_W + 1)'(pop);
    bit_next = bit_sum[CNT_W] ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
  end

  // Bit-error accumulator; clear wins over the same cycle's contribution.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_err_count <= '0;
    end else if (in_valid && state_reg == LOCKED) begin
      bit_err_count <= bit_next;
    end
  end
`endif

  // Hunt/lock state machine, flywheel predictor and word/error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= HUNT;
      ref_reg       <= '0;
      ref_vld_reg   <= 1'b0;
      match_cnt_reg <= '0;
      bad_cnt_reg   <= '0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
      word_count    <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        err_count  <= '0;
        word_count <= '0;
      end
      if (in_valid) begin
        case (state_reg)
          HUNT: begin
            ref_reg     <= in_data;
            ref_vld_reg <= 1'b1;
            if (hunt_match) begin
              if (match_cnt_reg + 4'd1 == LOCK_N) begin
                state_reg     <= LOCKED;
                bad_cnt_reg   <= '0;
                match_cnt_reg <= '0;
              end else begin
                match_cnt_reg <= match_cnt_reg + 4'd1;
              end
            end else begin
              match_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            // Flywheel: received data is never loaded while locked.
            ref_reg <= exp_word;
            if (!clear) begin
              word_count <= sat_inc(word_count);
            end
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (!clear) begin
                err_count <= sat_inc(err_count);
              end
              if (bad_cnt_reg + 8'd1 == LOSS_N) begin
                // Lost lock: restart the hunt seeded with this word.
                state_reg     <= HUNT;
                ref_reg       <= in_data;
                ref_vld_reg   <= 1'b1;
                match_cnt_reg <= '0;
                bad_cnt_reg   <= '0;
              end else begin
                bad_cnt_reg <= bad_cnt_reg + 8'd1;
              end
            end else begin
              bad_cnt_reg <= '0;
            end
          end
          default: begin
            state_reg <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: table-driven bench for prbs_checker with a scoreboard
// queue. Stimulus records carry hand-derived expected outputs.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] word_count;
`ifdef PRBS_CHECKER_BIT_ERR_EN
  logic [31:0] bit_err_count;
`endif

  prbs_checker dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count)
`ifdef PRBS_CHECKER_BIT_ERR_EN
    ,
    .bit_err_count (bit_err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        clr;
    logic [63:0] data;
    logic        e_locked;
    logic        e_pulse;
    logic [31:0] e_err;
    logic [31:0] e_words;
    logic        chk_bits;
    logic [31:0] e_bits;
  } vec_t;

  vec_t        table_q[$];
  vec_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          step  = 0;
  logic [63:0] g;

  // Reference pattern generator (sender side).
  function automatic logic [63:0] gen_next(input logic [63:0] d);
    return {d[1] ^ d[0], d[63:1]};
  endfunction

  function automatic logic [63:0] take_word();
    logic [63:0] w;
    w = g;
    g = gen_next(g);
    return w;
  endfunction

  task automatic add(input logic r, input logic v, input logic c, input logic [63:0] d,
                     input logic lk, input logic pu, input int er, input int wd,
                     input logic cb, input int bt);
    vec_t e;
    e.rst = r; e.valid = v; e.clr = c; e.data = d;
    e.e_locked = lk; e.e_pulse = pu; e.e_err = 32'(er); e.e_words = 32'(wd);
    e.chk_bits = cb; e.e_bits = 32'(bt);
    table_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // Drive one record, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; in_valid = v.valid; clear = v.clr; in_data = v.data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("locked", 64'(locked), 64'(e.e_locked));
    chk("err_pulse", 64'(err_pulse), 64'(e.e_pulse));
    chk("err_count", 64'(err_count), 64'(e.e_err));
    chk("word_count", 64'(word_count), 64'(e.e_words));
`ifdef PRBS_CHECKER_BIT_ERR_EN
    if (e.chk_bits) chk("bit_err_count", 64'(bit_err_count), 64'(e.e_bits));
`endif
    $display("[TB] step %0d rst=%0b v=%0b clr=%0b data=%016h locked=%0b pulse=%0b err=%0d words=%0d",
             step, e.rst, e.valid, e.clr, e.data, locked, err_pulse, err_count, word_count);
    step++;
  endtask

  initial begin
    logic [63:0] w;
    vec_t        z;
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; in_data = '0;
    g = 64'h0000_0000_0000_0202;

    // Reset state.
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Lock: locked after the 5th word.
    for (int i = 1; i <= 5; i++) add(0, 1, 0, take_word(), (i == 5), 0, 0, 0, 1, 0);
    add(0, 1, 0, take_word(), 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, take_word(), 1, 0, 0, 2, 1, 0);
    // Single error on bit 0, then flywheel carries on cleanly.
    w = take_word(); add(0, 1, 0, w ^ 64'h1, 1, 1, 1, 3, 1, 1);
    add(0, 1, 0, take_word(), 1, 0, 1, 4, 1, 1);
    add(0, 1, 0, take_word(), 1, 0, 1, 5, 1, 1);
    // Gaps change nothing.
    add(0, 0, 0, 64'hDEAD_BEEF, 1, 0, 1, 5, 1, 1);
    add(0, 0, 0, 0, 1, 0, 1, 5, 1, 1);
    // Bits 0 and 63 flipped: +2 bit errors.
    w = take_word(); add(0, 1, 0, w ^ 64'h8000_0000_0000_0001, 1, 1, 2, 6, 1, 3);
    add(0, 0, 0, 0, 1, 0, 2, 6, 1, 3);
    add(0, 1, 0, take_word(), 1, 0, 2, 7, 1, 3);
    // Clear with a corrupted word: counters zero, pulse still fires.
    w = take_word(); add(0, 1, 1, w ^ 64'h10, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0, take_word(), 1, 0, 0, 1, 1, 0);
    // Three errors to reach err_count=3.
    for (int i = 1; i <= 3; i++) begin
      w = take_word(); add(0, 1, 0, w ^ 64'h20, 1, 1, i, 1 + i, 1, i);
    end
    // Reset mid-lock.
    add(1, 1, 0, take_word(), 0, 0, 0, 0, 1, 0);
    // Full 5-word hunt needed again.
    for (int i = 1; i <= 5; i++) add(0, 1, 0, take_word(), (i == 5), 0, 0, 0, 1, 0);
    add(0, 1, 0, take_word(), 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, take_word(), 1, 0, 0, 2, 1, 0);
    // Loss of lock: 8 zero words, locked falls after the 8th.
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 0, (i != 8), 1, i, 2 + i, 0, 0);
    // Resume generator: relock after 5 further words.
    for (int i = 1; i <= 5; i++) add(0, 1, 0, take_word(), (i == 5), 0, 8, 10, 0, 0);
    add(0, 1, 0, take_word(), 1, 0, 8, 11, 0, 0);

    foreach (table_q[i]) apply(table_q[i]);

    // Zero stream from reset: never locks, counters stay zero.
    z.rst = 1; z.valid = 0; z.clr = 0; z.data = '0;
    z.e_locked = 0; z.e_pulse = 0; z.e_err = 0; z.e_words = 0;
    z.chk_bits = 1; z.e_bits = 0;
    apply(z);
    z.rst = 0; z.valid = 1;
    for (int i = 0; i < 20; i++) apply(z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
